// File: rtl/mac_frame_fifo_pkg.sv
// Shared types and constants for the store-and-forward MAC frame buffer.
package mac_frame_fifo_pkg;

  typedef enum logic [0:0] {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_e;

  localparam int DROP_CNT_W = 16;

  // Each stored entry is one data beat plus its end-of-frame flag.
  function automatic int entry_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/mac_frame_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module mac_frame_fifo_ram
  import mac_frame_fifo_pkg::*;
#(
  parameter int WIDTH  = entry_w(8),
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; the pointer
  // logic guarantees no entry is read before it has been written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mac_frame_fifo.sv
// Store-and-forward frame buffer: commits only complete, error-free frames of
// at most MAX_FRAME beats. Define MAC_FRAME_FIFO_STATS_EN for drop/ok counters.
module mac_frame_fifo
  import mac_frame_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2048,
  parameter int MAX_FRAME = 1518,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  input  logic                  rx_err,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  full,
  output logic                  frame_avail,
  output logic [ADDR_W:0]       frame_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int EW    = entry_w(DATA_W);
  localparam int LEN_W = $clog2(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_FRAME);
  localparam logic [ADDR_W:0]  DEPTH_PTR = (ADDR_W + 1)'(DEPTH);

  typedef logic [ADDR_W:0] ptr_t;

  ptr_t             wr_ptr, wr_commit, commit_q, rd_ptr, rd_next;
  logic [LEN_W-1:0] len;
  wr_state_e        state;
  logic             accept, drop, commit, load, tx_done;
  logic [EW-1:0]    rd_entry;

  assign full = (wr_ptr - rd_ptr) == DEPTH_PTR;

  // NOTE: every output of an always_comb gets a default first so no latch
  // is inferred on paths that do not assign it.
  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    if (rx_valid && state == WR_ACCEPT) begin
      if (!full && !rx_err && len != MAX_LEN) accept = 1'b1;
      else                                    drop   = 1'b1;
    end
  end

  assign commit = accept & rx_last;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WR_ACCEPT;
      wr_ptr    <= '0;
      wr_commit <= '0;
      len       <= '0;
    end else begin
      case (state)
        WR_ACCEPT: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (rx_last) begin
              wr_commit <= wr_ptr + 1'b1;
              len       <= '0;
            end else begin
              len <= len + 1'b1;
            end
          end else if (drop) begin
            wr_ptr <= wr_commit;
            len    <= '0;
            if (!rx_last) state <= WR_DROP;
          end
        end
        WR_DROP:  if (rx_valid && rx_last) state <= WR_ACCEPT;
        default:  state <= WR_ACCEPT;
      endcase
    end
  end

  // The RAM is re-read at the head every cycle; comparing against a one-cycle
  // delayed commit pointer ensures the sampled word was written before the read.
  assign load    = (!tx_valid || tx_ready) && (rd_ptr != commit_q);
  assign rd_next = load ? rd_ptr + 1'b1 : rd_ptr;
  assign tx_done = tx_valid & tx_ready & tx_last;

  mac_frame_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (accept),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata({rx_last, rx_data}),
    .raddr(rd_next[ADDR_W-1:0]),
    .rdata(rd_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_q <= '0;
      rd_ptr   <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_data  <= '0;
    end else begin
      commit_q <= wr_commit;
      rd_ptr   <= rd_next;
      if (load) begin
        tx_valid <= 1'b1;
        tx_last  <= rd_entry[DATA_W];
        tx_data  <= rd_entry[DATA_W-1:0];
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else begin
      case ({commit, tx_done})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  assign frame_avail = frame_cnt != '0;

`ifdef MAC_FRAME_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] drop_q, ok_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
      ok_cnt <= '0;
    end else begin
      if (drop && drop_q != '1)   drop_q <= drop_q + 1'b1;
      if (commit && ok_cnt != '1) ok_cnt <= ok_cnt + 1'b1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_frame_fifo.sv
// Directed bench for mac_frame_fifo: three instances cover default, DEPTH=16
// and MAX_FRAME=32 configurations; expected beats come from a local scoreboard.
module tb_mac_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_last, rx_err;
  logic       rx_valid_a, rx_valid_b, rx_valid_c;
  logic       ready_a_dir, stall_bit, rand_stall;
  logic       tx_ready_a, tx_ready_b, tx_ready_c;

  logic [7:0]  tx_data_a, tx_data_b, tx_data_c;
  logic        tx_valid_a, tx_valid_b, tx_valid_c;
  logic        tx_last_a, tx_last_b, tx_last_c;
  logic        full_a, full_b, full_c;
  logic        frame_avail_a, frame_avail_b, frame_avail_c;
  logic [11:0] frame_cnt_a;
  logic [4:0]  frame_cnt_b;
  logic [6:0]  frame_cnt_c;
  logic [15:0] drop_cnt_a, drop_cnt_b, drop_cnt_c;

  assign tx_ready_a = rand_stall ? stall_bit : ready_a_dir;
  always @(posedge clk) stall_bit <= ($urandom_range(0, 4) != 0);

  mac_frame_fifo u_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_a),
    .rx_last(rx_last), .rx_err(rx_err), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_last(tx_last_a), .tx_ready(tx_ready_a), .full(full_a),
    .frame_avail(frame_avail_a), .frame_cnt(frame_cnt_a), .drop_cnt(drop_cnt_a)
  );

  mac_frame_fifo #(.DEPTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_b),
    .rx_last(rx_last), .rx_err(rx_err), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_last(tx_last_b), .tx_ready(tx_ready_b), .full(full_b),
    .frame_avail(frame_avail_b), .frame_cnt(frame_cnt_b), .drop_cnt(drop_cnt_b)
  );

  mac_frame_fifo #(.DEPTH(64), .MAX_FRAME(32)) u_c (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_c),
    .rx_last(rx_last), .rx_err(rx_err), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
    .tx_last(tx_last_c), .tx_ready(tx_ready_c), .full(full_c),
    .frame_avail(frame_avail_c), .frame_cnt(frame_cnt_c), .drop_cnt(drop_cnt_c)
  );

  int tests  = 0;
  int failed = 0;
  logic [8:0] qa[$], qb[$], qc[$], exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_valid_a && tx_ready_a) qa.push_back({tx_last_a, tx_data_a});
    if (rst_n && tx_valid_b && tx_ready_b) qb.push_back({tx_last_b, tx_data_b});
    if (rst_n && tx_valid_c && tx_ready_c) qc.push_back({tx_last_c, tx_data_c});
  end

  // Output of instance a must hold while it is stalled.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {tx_valid_a, tx_last_a, tx_data_a}, {1'b1, prev_beat});
      prev_stall <= tx_valid_a & !tx_ready_a;
      prev_beat  <= {tx_last_a, tx_data_a};
    end
  end

  function automatic int qsize(input int inst);
    case (inst)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [8:0] qget(input int inst, input int i);
    case (inst)
      0:       return qa[i];
      1:       return qb[i];
      default: return qc[i];
    endcase
  endfunction

  task automatic set_valid(input int inst, input logic v);
    case (inst)
      0:       rx_valid_a = v;
      1:       rx_valid_b = v;
      default: rx_valid_c = v;
    endcase
  endtask

  // Sends len beats start, start+1, ...; returns #1 after the edge that took the last beat.
  task automatic send(input int inst, input int len, input logic [7:0] start,
                      input int err_idx, input bit record);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      rx_data = start + 8'(i);
      rx_last = (i == len - 1);
      rx_err  = (i == err_idx);
      set_valid(inst, 1'b1);
      if (record) exp_q.push_back({rx_last, rx_data});
    end
    @(posedge clk); #1;
    set_valid(inst, 1'b0);
    rx_last = 1'b0;
    rx_err  = 1'b0;
  endtask

  task automatic compare(input int inst, input string tag);
    int n;
    int budget;
    n      = exp_q.size();
    budget = 0;
    while (qsize(inst) < n && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(qsize(inst)), 64'(n));
    for (int i = 0; i < n && i < qsize(inst); i++) check(tag, qget(inst, i), exp_q[i]);
    exp_q.delete();
    case (inst)
      0:       qa.delete();
      1:       qb.delete();
      default: qc.delete();
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_frames;
    int len;
    rst_n = 1'b0;
    rx_data = '0; rx_last = 1'b0; rx_err = 1'b0;
    rx_valid_a = 1'b0; rx_valid_b = 1'b0; rx_valid_c = 1'b0;
    ready_a_dir = 1'b1; rand_stall = 1'b0;
    tx_ready_b = 1'b1; tx_ready_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", {tx_valid_a, tx_last_a, tx_data_a, full_a, frame_avail_a, frame_cnt_a, drop_cnt_a}, 0);
    check("rst_b", {tx_valid_b, tx_last_b, tx_data_b, full_b, frame_avail_b, frame_cnt_b, drop_cnt_b}, 0);
    check("rst_c", {tx_valid_c, tx_last_c, tx_data_c, full_c, frame_avail_c, frame_cnt_c, drop_cnt_c}, 0);
    rst_n = 1'b1;

    // 64-beat frame, latency and frame_cnt
    send(0, 64, 8'h00, -1, 1'b1);
    check("t1_cnt_commit", frame_cnt_a, 1);
    check("t1_valid_n", tx_valid_a, 0);
    @(posedge clk); #1;
    check("t1_valid_n1", tx_valid_a, 0);
    @(posedge clk); #1;
    check("t1_valid_n2", tx_valid_a, 1);
    check("t1_first", {tx_last_a, tx_data_a}, 9'h000);
    compare(0, "t1_beat");
    check("t1_cnt_end", frame_cnt_a, 0);
    check("t1_avail_end", frame_avail_a, 0);

    // errored frames dropped, pointer rewound, good frame passes
    send(0, 30, 8'h80, 10, 1'b0);
    check("t2_rewind_err", u_a.wr_ptr, 64);
    send(0, 3, 8'h90, 2, 1'b0);
    check("t2_rewind_errlast", u_a.wr_ptr, 64);
    send(0, 20, 8'h40, -1, 1'b1);
    compare(0, "t2_beat");
`ifdef MAC_FRAME_FIFO_STATS_EN
    check("t2_drop", drop_cnt_a, 2);
`else
    check("t2_drop", drop_cnt_a, 0);
`endif

    // DEPTH=16: third frame hits full and is dropped
    tx_ready_b = 1'b0;
    send(1, 6, 8'h10, -1, 1'b1);
    send(1, 6, 8'h20, -1, 1'b1);
    send(1, 6, 8'h30, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_frame_cnt", frame_cnt_b, 2);
    check("t3_avail", frame_avail_b, 1);
    check("t3_rewind", u_b.wr_ptr, 12);
    check("t3_full_after", full_b, 0);
    check("t3_nothing_out", qb.size(), 0);
`ifdef MAC_FRAME_FIFO_STATS_EN
    check("t3_drop", drop_cnt_b, 1);
`else
    check("t3_drop", drop_cnt_b, 0);
`endif
    tx_ready_b = 1'b1;
    compare(1, "t3_beat");
    check("t3_cnt_end", frame_cnt_b, 0);

    // MAX_FRAME=32: 40 beats dropped, exactly 32 and 8 pass
    send(2, 40, 8'h00, -1, 1'b0);
    send(2, 32, 8'h60, -1, 1'b1);
    send(2, 8, 8'hA0, -1, 1'b1);
    compare(2, "t4_beat");
`ifdef MAC_FRAME_FIFO_STATS_EN
    check("t4_drop", drop_cnt_c, 1);
`else
    check("t4_drop", drop_cnt_c, 0);
`endif

    // 200 random-length frames with random tx_ready stalls
    rand_stall = 1'b1;
    bad_frames = 0;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 64);
      if (f % 9 == 4) begin
        bad_frames++;
        send(0, len, 8'($urandom), $urandom_range(0, len - 1), 1'b0);
      end else begin
        send(0, len, 8'($urandom), -1, 1'b1);
      end
    end
    compare(0, "t5_beat");
    rand_stall = 1'b0;
    check("t5_cnt_end", frame_cnt_a, 0);
`ifdef MAC_FRAME_FIFO_STATS_EN
    check("t5_drop", drop_cnt_a, 64'(2 + bad_frames));
`else
    check("t5_drop", drop_cnt_a, 0);
`endif

    // reset mid-frame with a committed frame stalled at the output
    ready_a_dir = 1'b0;
    send(0, 5, 8'hE0, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_pre_valid", tx_valid_a, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rx_data = 8'hD0 + 8'(i);
      rx_valid_a = 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx_valid_a = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_out", {tx_valid_a, tx_last_a, tx_data_a, full_a, frame_avail_a, frame_cnt_a, drop_cnt_a}, 0);
    check("t6_rst_wr_ptr", u_a.wr_ptr, 0);
    rst_n = 1'b1;
    ready_a_dir = 1'b1;
    qa.delete();
    exp_q.delete();
    send(0, 16, 8'hC0, -1, 1'b1);
    compare(0, "t6_beat");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
